// File: rtl/risc16_pkg.sv
// Shared constants for the RISC16 multi-cycle core: opcodes, FSM state codes,
// instruction field positions and the register-file geometry.
package risc16_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam int unsigned OPC_HI   = 15;
    localparam int unsigned OPC_LO   = 13;
    localparam int unsigned RA_HI    = 12;
    localparam int unsigned RA_LO    = 10;
    localparam int unsigned RB_HI    = 9;
    localparam int unsigned RB_LO    = 7;
    localparam int unsigned RC_HI    = 2;
    localparam int unsigned RC_LO    = 0;
    localparam int unsigned IMM10_HI = 9;
    localparam int unsigned SIMM7_HI = 6;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned REG_W    = 16;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

endpackage

// File: rtl/risc16_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port,
// r0 reads as zero and ignores writes.
module risc16_regfile
    import risc16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ra1_i,
    output logic [REG_W-1:0] rd1_o,
    input  logic [2:0]       ra2_i,
    output logic [REG_W-1:0] rd2_o,
    input  logic             we_i,
    input  logic [2:0]       wa_i,
    input  logic [REG_W-1:0] wd_i
);

    logic [REG_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 3'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 3'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 3'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/risc16_mc_core.sv
// RISC16 multi-cycle core: FETCH -> EXEC (-> MEM) -> FETCH, with a terminal
// HALT state left only through reset.
module risc16_mc_core
    import risc16_pkg::*;
#(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [PC_W-1:0] dmem_addr,
    output logic [15:0]     dmem_wdata,
    input  logic            dmem_ack,
    input  logic [15:0]     dmem_rdata,
    output logic            halted
);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            run_q;

    logic [2:0]      opc, fa, fb, fc, rs1_sel;
    logic [9:0]      imm10;
    logic [15:0]     simm, rs1_val, rb_val, rf_wd;
    logic            rf_we, is_halt, in_mem;
    logic [PC_W-1:0] pc_inc;

    assign opc   = ir_q[OPC_HI:OPC_LO];
    assign fa    = ir_q[RA_HI:RA_LO];
    assign fb    = ir_q[RB_HI:RB_LO];
    assign fc    = ir_q[RC_HI:RC_LO];
    assign imm10 = ir_q[IMM10_HI:0];
    assign simm  = sext7(ir_q[SIMM7_HI:0]);

    // ADD/NAND read rb and rc; BEQ/SW read ra and rb, so port 1 is muxed.
    assign rs1_sel = ((opc == OP_ADD) || (opc == OP_NAND)) ? fc : fa;
    assign pc_inc  = pc_q + PC_W'(1);
    assign is_halt = (opc == OP_JALR) && (fa == 3'd0) && (fb == 3'd0)
                     && (ir_q[SIMM7_HI:0] != 7'd0);

    risc16_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs1_sel),
        .rd1_o (rs1_val),
        .ra2_i (fb),
        .rd2_o (rb_val),
        .we_i  (rf_we),
        .wa_i  (fa),
        .wd_i  (rf_wd)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rf_we   = 1'b0;
        rf_wd   = '0;
        case (state_q)
            ST_FETCH: begin
                if (run_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (opc)
                    OP_ADD:  begin rf_we = 1'b1; rf_wd = rb_val + rs1_val; end
                    OP_ADDI: begin rf_we = 1'b1; rf_wd = rb_val + simm; end
                    OP_NAND: begin rf_we = 1'b1; rf_wd = ~(rb_val & rs1_val); end
                    OP_LUI:  begin rf_we = 1'b1; rf_wd = {imm10, 6'b0}; end
                    OP_SW, OP_LW: begin
                        state_d = ST_MEM;
                        pc_d    = pc_q;
                    end
                    OP_BEQ: begin
                        if (rs1_val == rb_val) begin
                            pc_d = pc_inc + simm[PC_W-1:0];
                        end
                    end
                    OP_JALR: begin
                        if (is_halt) begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end else begin
                            rf_we = 1'b1;
                            rf_wd = 16'(pc_inc);
                            pc_d  = rb_val[PC_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (opc == OP_LW) begin
                        rf_we = 1'b1;
                        rf_wd = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // run_q keeps imem_req low while reset is held and for the reset-release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= PC_W'(RESET_PC);
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            run_q   <= 1'b1;
        end
    end

    assign in_mem     = (state_q == ST_MEM);
    assign imem_req   = run_q && (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = in_mem;
    assign dmem_we    = in_mem && (opc == OP_SW);
    assign dmem_addr  = in_mem ? (rb_val[PC_W-1:0] + simm[PC_W-1:0]) : '0;
    assign dmem_wdata = in_mem ? rs1_val : '0;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_risc16_mc_core.sv
// Scoreboard bench for risc16_mc_core: expected fetch addresses and data
// accesses are queued per program and popped by a monitor on each ack.
module tb_risc16_mc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

    logic        rst_b_n = 1'b0;
    logic        b_imem_req, b_imem_ack, b_dmem_req, b_dmem_we, b_dmem_ack, b_halted;
    logic [3:0]  b_imem_addr, b_dmem_addr;
    logic [15:0] b_imem_rdata, b_dmem_wdata;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic [15:0] bimem [16];

    int unsigned i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
    int unsigned total = 0, bad = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  cycles;
    } dexp_t;

    logic [15:0] exp_if[$];
    dexp_t       exp_d[$];
    logic [3:0]  exp_bif[$];

    risc16_mc_core #(.PC_W(16), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted)
    );

    risc16_mc_core #(.PC_W(4), .RESET_PC(14)) dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
        .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
        .dmem_ack(b_dmem_ack), .dmem_rdata(16'h0000), .halted(b_halted)
    );

    // Memory responders with programmable ack wait states.
    assign imem_rdata   = imem[imem_addr[7:0]];
    assign dmem_rdata   = dmem[dmem_addr[7:0]];
    assign imem_ack     = imem_req && (i_cnt >= i_wait);
    assign dmem_ack     = dmem_req && (d_cnt >= d_wait);
    assign b_imem_rdata = bimem[b_imem_addr];
    assign b_imem_ack   = b_imem_req;
    assign b_dmem_ack   = b_dmem_req;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) i_cnt <= 0; else i_cnt <= i_cnt + 1;
        if (!dmem_req || dmem_ack) d_cnt <= 0; else d_cnt <= d_cnt + 1;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] ra,
                                          input logic [2:0] rb, input logic [2:0] rc);
        return {op, ra, rb, 4'b0000, rc};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] ra,
                                          input logic [2:0] rb, input logic [6:0] s);
        return {op, ra, rb, s};
    endfunction

    function automatic logic [15:0] enc_lui(input logic [2:0] ra, input logic [9:0] imm);
        return {3'b011, ra, imm};
    endfunction

    task automatic push_d(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [7:0] cycles);
        dexp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.cycles = cycles;
        exp_d.push_back(e);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge with rst_n low; releases reset and waits for halted.
    task automatic run_until_halt(input string name, output int unsigned halt_n);
        halt_n = 0;
        rst_n  = 1'b1;
        for (int unsigned k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) check({name, "_first_req"}, 32'(imem_req), 32'd1);
            if (halted) begin
                halt_n = k;
                break;
            end
        end
        check({name, "_halted"}, 32'(halted), 32'd1);
        check({name, "_fetch_left"}, 32'(exp_if.size()), 32'd0);
        check({name, "_data_left"}, 32'(exp_d.size()), 32'd0);
        exp_if.delete();
        exp_d.delete();
    endtask

    // Monitor for the main instance: fetches pop on ack; data requests are
    // compared every pending cycle so any drift before the ack is caught.
    initial begin
        logic [15:0] ea;
        dexp_t       ed;
        int unsigned dcnt;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                if (exp_if.size() == 0) begin
                    check("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
                end else begin
                    ea = exp_if.pop_front();
                    check("fetch_addr", 32'(imem_addr), 32'(ea));
                end
            end
            if (dmem_req) begin
                if (exp_d.size() == 0) begin
                    check("dmem_unexpected", 32'(dmem_addr), 32'hFFFF_FFFF);
                end else begin
                    ed = exp_d[0];
                    dcnt++;
                    check("dmem_we", 32'(dmem_we), 32'(ed.we));
                    check("dmem_addr", 32'(dmem_addr), 32'(ed.addr));
                    check("dmem_wdata", 32'(dmem_wdata), 32'(ed.wdata));
                    if (dmem_ack) begin
                        check("dmem_req_cycles", dcnt, 32'(ed.cycles));
                        void'(exp_d.pop_front());
                        dcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] eb;
        forever begin
            @(negedge clk);
            if (b_imem_req && b_imem_ack) begin
                if (exp_bif.size() == 0) begin
                    check("b_fetch_unexpected", 32'(b_imem_addr), 32'hFFFF_FFFF);
                end else begin
                    eb = exp_bif.pop_front();
                    check("b_fetch_addr", 32'(b_imem_addr), 32'(eb));
                end
            end
            if (b_dmem_req) check("b_dmem_unexpected", 32'(b_dmem_addr), 32'hFFFF_FFFF);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hn;
        for (int i = 0; i < 16; i++) bimem[i] = 16'h0000;
        clear_imem();
        @(negedge clk);
        @(negedge clk);

        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);

        // ADDI/ADDI/ADD, result stored to dmem[0]; 11 cycles from first fetch to halted.
        imem[0] = 16'h2405;                      // ADDI r1,r0,5
        imem[1] = 16'h287D;                      // ADDI r2,r0,-3
        imem[2] = 16'h0C82;                      // ADD  r3,r1,r2
        imem[3] = enc_i(3'b100, 3'd3, 3'd0, 7'd0);
        imem[4] = 16'hE001;
        for (int i = 0; i <= 4; i++) exp_if.push_back(16'(i));
        push_d(1'b1, 16'h0000, 16'h0002, 8'd1);
        run_until_halt("alu", hn);
        check("alu_halt_latency", hn, 32'd12);

        // LUI/ADDI build 0xFFFF, NAND of it with itself gives 0.
        hold_reset();
        clear_imem();
        imem[0] = enc_lui(3'd1, 10'h3FF);
        imem[1] = enc_i(3'b001, 3'd1, 3'd1, 7'h3F);
        imem[2] = enc_r(3'b010, 3'd2, 3'd1, 3'd1);
        imem[3] = enc_i(3'b100, 3'd1, 3'd0, 7'd0);
        imem[4] = enc_i(3'b100, 3'd2, 3'd0, 7'd1);
        imem[5] = 16'hE001;
        for (int i = 0; i <= 5; i++) exp_if.push_back(16'(i));
        push_d(1'b1, 16'h0000, 16'hFFFF, 8'd1);
        push_d(1'b1, 16'h0001, 16'h0000, 8'd1);
        run_until_halt("lui_nand", hn);

        // SW then LW through a 3-wait-state data memory.
        hold_reset();
        clear_imem();
        d_wait  = 3;
        imem[0] = enc_i(3'b001, 3'd1, 3'd0, 7'h2A);
        imem[1] = enc_i(3'b100, 3'd1, 3'd0, 7'd4);
        imem[2] = enc_i(3'b101, 3'd2, 3'd0, 7'd4);
        imem[3] = enc_i(3'b100, 3'd2, 3'd0, 7'd5);
        imem[4] = 16'hE001;
        for (int i = 0; i <= 4; i++) exp_if.push_back(16'(i));
        push_d(1'b1, 16'h0004, 16'h002A, 8'd4);
        push_d(1'b0, 16'h0004, 16'h0000, 8'd4);
        push_d(1'b1, 16'h0005, 16'h002A, 8'd4);
        run_until_halt("mem_wait", hn);
        d_wait = 0;

        // BEQ r0,r0,-1 at pc=5 loops on itself; stop it with reset.
        hold_reset();
        clear_imem();
        imem[0] = enc_i(3'b001, 3'd1, 3'd0, 7'd1);
        imem[1] = enc_i(3'b001, 3'd2, 3'd0, 7'd2);
        imem[5] = enc_i(3'b110, 3'd0, 3'd0, 7'h7F);
        for (int i = 0; i <= 5; i++) exp_if.push_back(16'(i));
        exp_if.push_back(16'd5);
        exp_if.push_back(16'd5);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (exp_if.size() == 0) break;
        end
        #1 rst_n = 1'b0;
        check("beq_taken_fetch_left", 32'(exp_if.size()), 32'd0);
        exp_if.delete();
        @(negedge clk);

        // BEQ r1,r2 with r1 != r2 falls through to pc=6.
        hold_reset();
        imem[5] = enc_i(3'b110, 3'd1, 3'd2, 7'h7F);
        imem[6] = 16'hE001;
        for (int i = 0; i <= 6; i++) exp_if.push_back(16'(i));
        run_until_halt("beq_not_taken", hn);

        // JALR r0,r4 to 0x10 (link discarded), JALR r7,r3 to 0x40, then store r7 and r0.
        hold_reset();
        clear_imem();
        imem[0]     = enc_lui(3'd3, 10'd1);
        imem[1]     = enc_i(3'b001, 3'd4, 3'd0, 7'h10);
        imem[2]     = enc_i(3'b111, 3'd0, 3'd4, 7'd0);
        imem[16]    = enc_i(3'b111, 3'd7, 3'd3, 7'd0);
        imem[64]    = enc_i(3'b100, 3'd7, 3'd0, 7'd0);
        imem[65]    = enc_i(3'b100, 3'd0, 3'd0, 7'd1);
        imem[66]    = 16'hE001;
        exp_if.push_back(16'h0000); exp_if.push_back(16'h0001); exp_if.push_back(16'h0002);
        exp_if.push_back(16'h0010); exp_if.push_back(16'h0040); exp_if.push_back(16'h0041);
        exp_if.push_back(16'h0042);
        push_d(1'b1, 16'h0000, 16'h0011, 8'd1);
        push_d(1'b1, 16'h0001, 16'h0000, 8'd1);
        run_until_halt("jalr", hn);

        // HALT at pc=7, then reset during a stalled fetch.
        hold_reset();
        clear_imem();
        imem[7] = 16'hE001;
        for (int i = 0; i <= 7; i++) exp_if.push_back(16'(i));
        run_until_halt("halt", hn);
        repeat (5) @(negedge clk);
        check("halt_imem_req", 32'(imem_req), 32'd0);
        check("halt_dmem_req", 32'(dmem_req), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_pc", 32'(imem_addr), 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_imem_addr", 32'(imem_addr), 32'd0);
        i_wait = 5;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_imem_req", 32'(imem_req), 32'd1);
        check("stall_imem_addr", 32'(imem_addr), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midfetch_rst_req", 32'(imem_req), 32'd0);
        i_wait = 0;
        @(negedge clk);
        for (int i = 0; i <= 7; i++) exp_if.push_back(16'(i));
        run_until_halt("restart", hn);
        rst_n = 1'b0;

        // PC_W=4, RESET_PC=14: the PC wraps from 15 to 0.
        bimem[14] = 16'h0000;
        bimem[15] = enc_r(3'b000, 3'd1, 3'd0, 3'd0);
        bimem[0]  = 16'hE001;
        check("b_rst_imem_addr", 32'(b_imem_addr), 32'd14);
        check("b_rst_imem_req", 32'(b_imem_req), 32'd0);
        exp_bif.push_back(4'd14);
        exp_bif.push_back(4'd15);
        exp_bif.push_back(4'd0);
        rst_b_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (b_halted) break;
        end
        check("b_halted", 32'(b_halted), 32'd1);
        check("b_fetch_left", 32'(exp_bif.size()), 32'd0);
        check("b_halt_pc", 32'(b_imem_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
